// File: rtl/fsm_adc_pkg.sv
// Shared types and width helpers for the multi-channel ADC scan sequencer.
package fsm_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Channel index width; a single channel bit is kept even for NCH <= 2.
    function automatic int cw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w_f(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/adc_ch_next.sv
// Combinational search over an enable mask: next enabled channel above ch,
// whether ch is the last enabled one, and the lowest enabled channel.
module adc_ch_next
    import fsm_adc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = cw_f(NCH)
) (
    input  logic [NCH-1:0] mask,
    input  logic [CW-1:0]  ch,
    output logic [CW-1:0]  nxt,
    output logic           last,
    output logic [CW-1:0]  first
);

    logic [NCH-1:0] above;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_above
            assign above[gi] = mask[gi] && (CW'(gi) > ch);
        end
    endgenerate

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        nxt   = '0;
        first = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (above[i]) nxt = CW'(i);
            if (mask[i])  first = CW'(i);
        end
    end

    assign last = ~|above;

endmodule

// File: rtl/fsm_adc_nch.sv
// Moore sequencer that scans enabled ADC channels: start pulse, wait for
// end-of-conversion with timeout, then a one-hot hold strobe per channel.
module fsm_adc_nch
    import fsm_adc_pkg::*;
#(
    parameter int  NCH = 4,
    parameter int  TMO = 1023,
    localparam int CW  = cw_f(NCH),
    localparam int TW  = cnt_w_f(TMO)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           stm_i,
    input  logic           eoc_i,
    input  logic [NCH-1:0] en_i,
    input  logic           cont_i,
    output logic           strc_o,
    output logic [CW-1:0]  sel_o,
    output logic [NCH-1:0] h_o,
    output logic           eos_o,
    output logic           err_o
);

    state_t         state_reg, state_next;
    logic [CW-1:0]  ch_reg, ch_next;
    logic [NCH-1:0] mask_reg, mask_next;
    logic [TW-1:0]  cnt_reg, cnt_next;
    logic           err_reg, err_next;

    logic [NCH-1:0] src_mask;
    logic [CW-1:0]  nxt_ch, first_ch;
    logic           last_ch;

    // In IDLE the search looks at the incoming mask so the first channel is
    // known on the accepting edge; otherwise it walks the captured mask.
    assign src_mask = (state_reg == ST_IDLE) ? en_i : mask_reg;

    adc_ch_next #(
        .NCH (NCH),
        .CW  (CW)
    ) u_ch_next (
        .mask  (src_mask),
        .ch    (ch_reg),
        .nxt   (nxt_ch),
        .last  (last_ch),
        .first (first_ch)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            ch_reg    <= '0;
            mask_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            mask_reg  <= mask_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        mask_next  = mask_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (stm_i && (|en_i)) begin
                    mask_next  = en_i;
                    ch_next    = first_ch;
                    err_next   = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A conversion finishing on the timeout cycle still counts.
                if (eoc_i) begin
                    state_next = ST_HOLD;
                end else if (cnt_reg == TW'(TMO)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
            end
            ST_HOLD: begin
                if (!last_ch) begin
                    ch_next    = nxt_ch;
                    state_next = ST_START;
                end else if (cont_i) begin
                    ch_next    = first_ch;
                    state_next = ST_START;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        strc_o = (state_reg == ST_START);
        eos_o  = (state_reg == ST_IDLE);
        sel_o  = (state_reg == ST_IDLE) ? '0 : ch_reg;
        h_o    = (state_reg == ST_HOLD) ? (NCH'(1) << ch_reg) : '0;
    end

    assign err_o = err_reg;

endmodule

// File: tb/tb_fsm_adc_nch.sv
// Randomised scoreboard bench for fsm_adc_nch with a simple ADC responder.
module tb_fsm_adc_nch;

    localparam int NCH = 4;
    localparam int TMO = 15;
    localparam int CW  = 2;

    logic           clk_i  = 1'b0;
    logic           rst_i  = 1'b1;
    logic           stm_i  = 1'b0;
    logic           eoc_i  = 1'b0;
    logic [NCH-1:0] en_i   = '0;
    logic           cont_i = 1'b0;
    logic           strc_o;
    logic [CW-1:0]  sel_o;
    logic [NCH-1:0] h_o;
    logic           eos_o;
    logic           err_o;

    always #5 clk_i = ~clk_i;

    fsm_adc_nch #(
        .NCH (NCH),
        .TMO (TMO)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stm_i  (stm_i),
        .eoc_i  (eoc_i),
        .en_i   (en_i),
        .cont_i (cont_i),
        .strc_o (strc_o),
        .sel_o  (sel_o),
        .h_o    (h_o),
        .eos_o  (eos_o),
        .err_o  (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int strc_q[$];
    int hold_q[$];

    // 0: ADC silent, 1: fixed delay, 2: random delay 1..10
    int adc_mode  = 0;
    int adc_fixed = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: an accepted scan visits enabled channels in ascending order,
    // once per round, each giving one start and one hold.
    function automatic void push_scan(input logic [NCH-1:0] en, input int rounds);
        for (int r = 0; r < rounds; r++)
            for (int k = 0; k < NCH; k++)
                if (en[k]) begin
                    strc_q.push_back(k);
                    hold_q.push_back(k);
                end
    endfunction

    function automatic int lowest(input logic [NCH-1:0] en);
        for (int k = 0; k < NCH; k++)
            if (en[k]) return k;
        return 0;
    endfunction

    // ADC responder: eoc one cycle wide, d cycles after the start pulse
    int adc_d;
    initial begin
        forever begin
            @(negedge clk_i);
            if (strc_o && !rst_i && adc_mode != 0) begin
                adc_d = (adc_mode == 1) ? adc_fixed : int'($urandom_range(1, 10));
                repeat (adc_d) @(negedge clk_i);
                eoc_i = 1'b1;
                @(negedge clk_i);
                eoc_i = 1'b0;
            end
        end
    end

    // Monitor: every start pulse and hold strobe is matched against the queues
    int             mon_c;
    logic [NCH-1:0] mon_h;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (strc_o) begin
                    if (strc_q.size() == 0) begin
                        check("strc_unexpected", 32'(sel_o) + 100, 32'd0);
                    end else begin
                        mon_c = strc_q.pop_front();
                        check("strc_sel", 32'(sel_o), 32'(mon_c));
                    end
                end
                if (h_o != '0) begin
                    if (hold_q.size() == 0) begin
                        check("hold_unexpected", 32'(h_o), 32'd0);
                    end else begin
                        mon_c = hold_q.pop_front();
                        mon_h = '0;
                        mon_h[mon_c] = 1'b1;
                        check("hold_onehot", 32'(h_o), 32'(mon_h));
                        check("hold_sel", 32'(sel_o), 32'(mon_c));
                    end
                end
            end
        end
    end

    task automatic run_scan(input logic [NCH-1:0] en, input int rounds, input int mode);
        int n, holds, cyc;
        bit drop_pend, first_strc;
        n = $countones(en);
        adc_mode = mode;
        push_scan(en, rounds);
        en_i   = en;
        stm_i  = 1'b1;
        cont_i = (rounds > 1);
        @(negedge clk_i);
        stm_i = 1'b0;
        en_i  = NCH'($urandom);
        holds = 0;
        cyc = 0;
        drop_pend = 1'b0;
        first_strc = 1'b1;
        while (!eos_o && cyc < 3000) begin
            if (drop_pend) begin
                cont_i = 1'b0;
                drop_pend = 1'b0;
            end
            if (strc_o && first_strc) begin
                check("err_cleared", 32'(err_o), 32'd0);
                first_strc = 1'b0;
            end
            if (h_o != '0) begin
                holds++;
                if (rounds > 1 && holds == (rounds - 1) * n) drop_pend = 1'b1;
            end
            stm_i = strc_o && ($urandom_range(0, 1) == 1);
            @(negedge clk_i);
            cyc++;
        end
        stm_i  = 1'b0;
        cont_i = 1'b0;
        if (cyc >= 3000) check("scan_budget", 32'd1, 32'd0);
        check("scan_holds", 32'(holds), 32'(rounds * n));
        check("scan_eos", 32'(eos_o), 32'd1);
        check("scan_err", 32'(err_o), 32'd0);
        check("strc_q_drained", 32'(strc_q.size()), 32'd0);
        check("hold_q_drained", 32'(hold_q.size()), 32'd0);
        $display("scan en=%b rounds=%0d holds=%0d cycles=%0d", en, rounds, holds, cyc);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic run_timeout(input logic [NCH-1:0] en);
        int cyc;
        adc_mode = 0;
        strc_q.push_back(lowest(en));
        en_i   = en;
        cont_i = 1'b0;
        stm_i  = 1'b1;
        @(negedge clk_i);
        stm_i = 1'b0;
        check("tmo_strc", 32'(strc_o), 32'd1);
        cyc = 0;
        while (!err_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        check("tmo_latency", 32'(cyc), 32'(TMO + 2));
        check("tmo_eos", 32'(eos_o), 32'd1);
        check("tmo_h", 32'(h_o), 32'd0);
        $display("timeout en=%b err after %0d cycles", en, cyc);
    endtask

    logic [NCH-1:0] rnd_en;
    int             wait_c;

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_eos", 32'(eos_o), 32'd1);
        check("rst_strc", 32'(strc_o), 32'd0);
        check("rst_sel", 32'(sel_o), 32'd0);
        check("rst_h", 32'(h_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        adc_fixed = 3;
        run_scan(4'b1111, 1, 1);
        run_scan(4'b1010, 1, 1);
        run_scan(4'b0011, 3, 2);

        run_timeout(4'b0110);
        // An empty mask must not start a scan nor touch the sticky error.
        en_i  = '0;
        stm_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("empty_eos", 32'(eos_o), 32'd1);
            check("empty_err", 32'(err_o), 32'd1);
        end
        stm_i = 1'b0;
        $display("empty mask request ignored");
        run_scan(4'b1111, 1, 2);

        // Reset while channel 2 is waiting for its conversion
        adc_mode  = 1;
        adc_fixed = 12;
        push_scan(4'b1111, 1);
        en_i  = 4'b1111;
        stm_i = 1'b1;
        @(negedge clk_i);
        stm_i = 1'b0;
        wait_c = 0;
        while (!(strc_o && sel_o == 2'd2) && wait_c < 200) begin
            @(negedge clk_i);
            wait_c++;
        end
        check("rst_reach_ch2", 32'(wait_c < 200), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        strc_q.delete();
        hold_q.delete();
        @(negedge clk_i);
        check("midrst_eos", 32'(eos_o), 32'd1);
        check("midrst_h", 32'(h_o), 32'd0);
        check("midrst_sel", 32'(sel_o), 32'd0);
        check("midrst_strc", 32'(strc_o), 32'd0);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("midrst_idle", 32'(eos_o), 32'd1);
        $display("mid-scan reset handled");

        for (int i = 0; i < 10; i++) begin
            rnd_en = NCH'($urandom_range(1, (1 << NCH) - 1));
            run_scan(rnd_en, int'($urandom_range(1, 3)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
